// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StFetch = 2'b01,
        StHold  = 2'b10,
        StDrain = 2'b11
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // Force an address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target: jump beats branch, both relative to base.
module pc_target_calc (
    input  logic [31:0] base_i,
    input  logic        br_taken_i,
    input  logic [15:0] br_imm_i,
    input  logic        jump_i,
    input  logic [25:0] jump_target_i,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    // Select jump region target or sign-extended word-offset branch target.
    always_comb begin
        redirect_o = br_taken_i | jump_i;
        if (jump_i) begin
            target_o = {base_i[31:28], jump_target_i, 2'b00};
        end else begin
            target_o = base_i + {{14{br_imm_i[15]}}, br_imm_i, 2'b00};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit with branch/jump redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [5:0]  opcode,
    input  logic        br_taken,
    input  logic [15:0] br_imm,
    input  logic        jump,
    input  logic [25:0] jump_target
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] base_q, base_d;
    logic [31:0] drain_addr_q, drain_addr_d;

    logic        redirect;
    logic [31:0] target;

    pc_target_calc u_pc_target_calc (
        .base_i        (base_q),
        .br_taken_i    (br_taken),
        .br_imm_i      (br_imm),
        .jump_i        (jump),
        .jump_target_i (jump_target),
        .redirect_o    (redirect),
        .target_o      (target)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect always wins over ack or ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: begin
                if (redirect) begin
                    state_d = imem_ack ? StFetch : StDrain;
                end else if (imem_ack) begin
                    state_d = StHold;
                end
            end
            StHold:  if (redirect || inst_ready) state_d = StFetch;
            StDrain: if (imem_ack) state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: pc, held instruction, branch base, drain address.
    always_comb begin
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        base_d       = base_q;
        drain_addr_d = drain_addr_q;
        unique case (state_q)
            StFetch: begin
                if (redirect) begin
                    pc_d = align_word(target);
                    // Request stays on the bus at its old address until acked.
                    if (!imem_ack) drain_addr_d = pc_q;
                end else if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    pc_d      = pc_q + 32'd4;
                end
            end
            StHold: begin
                if (redirect) begin
                    pc_d = align_word(target);
                end else if (inst_ready) begin
                    base_d = inst_pc_q + 32'd4;
                end
            end
            StDrain: if (redirect) pc_d = align_word(target);
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= align_word(RESET_PC);
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            base_q       <= 32'h0;
            drain_addr_q <= 32'h0;
        end else begin
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            base_q       <= base_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = 32'h0;
        inst_valid = 1'b0;
        unique case (state_q)
            StFetch: begin
                imem_req  = 1'b1;
                imem_addr = align_word(pc_q);
            end
            StDrain: begin
                imem_req  = 1'b1;
                imem_addr = align_word(drain_addr_q);
            end
            StHold:  inst_valid = 1'b1;
            default: ;
        endcase
        inst    = inst_q;
        inst_pc = inst_pc_q;
        opcode  = inst_q[31:26];
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  32  word-aligned fetch address.
REQ-006 imem_ack  in  1  single-cycle response strobe; imem_rdata valid this cycle.
REQ-007 imem_rdata  in  32  fetched instruction word.
REQ-008 inst_valid  out  1  instruction presented to decode.
REQ-009 inst_ready  in  1  decode accepts instruction.
REQ-010 inst  out  32  held instruction word.
REQ-011 inst_pc  out  32  address of held instruction.
REQ-012 opcode  out  6  inst[31:26]; feeds control-unit opcode input.
REQ-013 br_taken  in  1  resolved taken branch for last accepted instruction.
REQ-014 br_imm  in  16  branch immediate, signed word offset.
REQ-015 jump  in  1  jump for last accepted instruction.
REQ-016 jump_target  in  26  jump instr_index field.

Function
REQ-017 FSM states: IDLE, FETCH, HOLD, DRAIN; encoding from package.
REQ-018 IDLE: all outputs 0; next cycle -> FETCH.
REQ-019 FETCH: imem_req=1, imem_addr=pc; both held stable until imem_ack.
REQ-020 FETCH + imem_ack, no redirect: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4, -> HOLD.
REQ-021 HOLD: inst_valid=1, inst/inst_pc stable; inst_ready=1 -> FETCH next cycle.
REQ-022 Latency: ack in cycle N -> inst_valid in cycle N+1; ready in cycle M -> imem_req in cycle M+1.
REQ-023 Base address base = last accepted inst_pc + 4, registered at inst_valid&inst_ready.
REQ-024 Redirect = br_taken|jump; jump target {base[31:28], jump_target, 2'b00}; branch target base + (sext(br_imm)<<2).
REQ-025 jump and br_taken both high: jump wins.
REQ-026 Redirect in HOLD: held instruction discarded, inst_valid=0 next cycle, pc<=target, -> FETCH; overrides simultaneous inst_ready.
REQ-027 Redirect in FETCH without ack: pc<=target, -> DRAIN; outstanding request not retracted.
REQ-028 DRAIN: imem_req=1 at old address until ack; ack data discarded; -> FETCH at target.
REQ-029 Redirect in FETCH with imem_ack same cycle: data discarded, pc<=target, stay FETCH.
REQ-030 Redirect in DRAIN: pc<=newest target, stay DRAIN.
REQ-031 Redirect in IDLE: ignored.
REQ-032 pc arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-033 imem_addr[1:0] forced 2'b00 at all times; RESET_PC low bits ignored.
REQ-034 inst_valid never high outside HOLD; imem_req never high outside FETCH/DRAIN.

Reset
REQ-035 rst_n=0 at rising edge: state<=IDLE, pc<=RESET_PC, inst<=0, inst_pc<=0, base<=0.
REQ-036 During reset cycles imem_req=0, inst_valid=0, opcode=0.
REQ-037 Reset mid-operation aborts in-flight fetch; a following stale imem_ack in IDLE is ignored.

Structure
REQ-038 Shared package fetch_pkg: state enum, RESET_PC default, opcode constants OP_RTYPE 6'b000000, OP_J 6'b000010, OP_BEQ 6'b000100.
REQ-039 One sub-module pc_target_calc: combinational target computation (REQ-024/025).
REQ-040 Target RTL size 120-400 lines total.

Verification
REQ-041 Reset release, ack after 3 cycles with 32'h2008_0005 -> imem_addr=0, inst_valid next cycle, opcode=6'b001000, inst_pc=0.
REQ-042 Back-to-back fetch, inst_ready always 1, ack latency 0 -> addresses 0,4,8,C; one instruction per 2 cycles.
REQ-043 Accept inst_pc=0x10, jump_target=26'h000_0040 during FETCH without ack -> DRAIN, old data dropped, next imem_addr=0x0000_0100.
REQ-044 Accept inst_pc=0x20, br_taken with br_imm=16'hFFFE in HOLD with inst_ready=1 -> held inst dropped, next imem_addr=0x1C.
REQ-045 RESET_PC=32'hFFFF_FFFC, two fetches -> imem_addr FFFF_FFFC then 0000_0000.
REQ-046 rst_n low during WAIT, ack arrives in IDLE -> no inst_valid; refetch from RESET_PC.
